// File: rtl/simple_alu_pipe.sv
// Two-operand ALU joining two valid-ready streams; the result travels through PipeStages register stages.
// Latency PipeStages cycles; full backpressure with bubble collapse, one result per cycle sustained.
module simple_alu_pipe #(
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned PipeStages = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DataWidth-1:0] a_i,
  input  logic                 a_valid_i,
  output logic                 a_ready_o,
  input  logic [DataWidth-1:0] b_i,
  input  logic                 b_valid_i,
  output logic                 b_ready_o,
  input  logic [2:0]           alu_config_i,
  output logic [DataWidth-1:0] result_o,
  output logic                 result_valid_o,
  input  logic                 result_ready_i,
  input  logic                 clear_count_i,
  output logic                 busy_o,
  output logic [31:0]          op_count_o
);
  localparam int unsigned Last = PipeStages - 1;

  localparam logic [2:0] OpAdd = 3'd0;
  localparam logic [2:0] OpSub = 3'd1;
  localparam logic [2:0] OpMul = 3'd2;
  localparam logic [2:0] OpXor = 3'd3;
  localparam logic [2:0] OpAnd = 3'd4;
  localparam logic [2:0] OpOr  = 3'd5;
  localparam logic [2:0] OpMin = 3'd6;
  localparam logic [2:0] OpMax = 3'd7;

  logic [PipeStages-1:0] stage_vld;
  logic [DataWidth-1:0]  stage_dat [PipeStages];
  logic [PipeStages-1:0] may_load;
  logic                  fire;
  logic                  out_hs;
  logic [DataWidth-1:0]  product;
  logic [DataWidth-1:0]  alu_res;
  logic [31:0]           count_q;

  assign out_hs = stage_vld[Last] && result_ready_i;

  // A stage can load unless it and every stage after it are full while the output stalls.
  for (genvar k = 0; k < PipeStages; k++) begin : g_may_load
    localparam logic [PipeStages-1:0] LowMask = (PipeStages'(1) << k) - PipeStages'(1);
    assign may_load[k] = result_ready_i || !(&(stage_vld | LowMask));
  end

  assign fire      = a_valid_i && b_valid_i && may_load[0];
  assign a_ready_o = fire;
  assign b_ready_o = fire;

  assign product = a_i * b_i;

  always_comb begin
    alu_res = '0;
    case (alu_config_i)
      OpAdd:   alu_res = a_i + b_i;
      OpSub:   alu_res = a_i - b_i;
      OpMul:   alu_res = product;
      OpXor:   alu_res = a_i ^ b_i;
      OpAnd:   alu_res = a_i & b_i;
      OpOr:    alu_res = a_i | b_i;
      OpMin:   alu_res = (a_i < b_i) ? a_i : b_i;
      OpMax:   alu_res = (a_i > b_i) ? a_i : b_i;
      default: alu_res = '0;
    endcase
  end

  for (genvar k = 0; k < PipeStages; k++) begin : g_stage
    logic                 in_vld;
    logic [DataWidth-1:0] in_dat;

    if (k == 0) begin : g_head
      assign in_vld = fire;
      assign in_dat = alu_res;
    end else begin : g_body
      assign in_vld = stage_vld[k-1];
      assign in_dat = stage_dat[k-1];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        stage_vld[k] <= 1'b0;
        stage_dat[k] <= '0;
      end else if (may_load[k]) begin
        stage_vld[k] <= in_vld;
        if (in_vld) begin
          stage_dat[k] <= in_dat;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (clear_count_i) begin
      count_q <= '0;
    end else if (out_hs) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign result_valid_o = stage_vld[Last];
  assign result_o       = stage_vld[Last] ? stage_dat[Last] : '0;
  assign busy_o         = |stage_vld;
  assign op_count_o     = count_q;

endmodule

// File: tb/tb_simple_alu_pipe.sv
// Bench for simple_alu_pipe: directed scenarios plus random traffic against a queue-based reference model.
module tb_simple_alu_pipe;
  localparam int DW = 8;
  localparam int P  = 3;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] a, b;
  logic          av, bv, rr, clr;
  logic [2:0]    op;
  logic          a_rdy, b_rdy, res_vld, busy;
  logic [DW-1:0] res;
  logic [31:0]   cnt;

  simple_alu_pipe #(.DataWidth(DW), .PipeStages(P)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .a_i           (a),
    .a_valid_i     (av),
    .a_ready_o     (a_rdy),
    .b_i           (b),
    .b_valid_i     (bv),
    .b_ready_o     (b_rdy),
    .alu_config_i  (op),
    .result_o      (res),
    .result_valid_o(res_vld),
    .result_ready_i(rr),
    .clear_count_i (clr),
    .busy_o        (busy),
    .op_count_o    (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] dat;
    int            fire_edge;
  } item_t;

  item_t       q[$];
  int          edges;
  logic [31:0] exp_count;
  int          vectors;
  int          miscompares;
  int          fires_seen;

  // Reference ALU in plain integer arithmetic, reduced modulo 2^DW.
  function automatic logic [DW-1:0] alu_ref(input int opc, input int x, input int y);
    int m;
    int r;
    m = 1 << DW;
    case (opc)
      0:       r = (x + y) % m;
      1:       r = (x - y + m) % m;
      2:       r = (x * y) % m;
      3:       r = x ^ y;
      4:       r = x & y;
      5:       r = x | y;
      6:       r = (x < y) ? x : y;
      default: r = (x > y) ? x : y;
    endcase
    return r[DW-1:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge with inputs applied; returns just after the next negedge.
  task automatic cycle();
    logic          ev, er, hs;
    logic [DW-1:0] ed;
    item_t         it;
    #1;
    ev = (q.size() > 0) && ((edges - q[0].fire_edge) >= P - 1);
    ed = ev ? q[0].dat : '0;
    er = av && bv && ((q.size() < P) || rr);
    check("result_valid", 64'(res_vld), 64'(ev));
    check("result", 64'(res), 64'(ed));
    check("busy", 64'(busy), 64'(q.size() != 0));
    check("a_ready", 64'(a_rdy), 64'(er));
    check("b_ready", 64'(b_rdy), 64'(er));
    check("op_count", 64'(cnt), 64'(exp_count));
    if (a_rdy) fires_seen++;
    hs = ev && rr;
    @(posedge clk);
    edges++;
    if (hs) void'(q.pop_front());
    if (er) begin
      it.dat       = alu_ref(int'(op), int'(a), int'(b));
      it.fire_edge = edges;
      q.push_back(it);
    end
    if (clr) exp_count = '0;
    else if (hs) exp_count = exp_count + 32'd1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    vectors = 0; miscompares = 0; edges = 0; exp_count = '0; fires_seen = 0;
    rst_n = 1'b0; av = 1'b1; bv = 1'b1; a = '0; b = '0; op = '0; rr = 1'b1; clr = 1'b0;

    // Reset values; ready follows a_valid && b_valid while empty.
    #2;
    check("rst_result_valid", 64'(res_vld), 64'(0));
    check("rst_result", 64'(res), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_op_count", 64'(cnt), 64'(0));
    check("rst_ready_both", 64'(a_rdy), 64'(1));
    av = 1'b0;
    #1;
    check("rst_ready_a_only", 64'(a_rdy), 64'(0));
    bv = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single add 5+3.
    a = 8'd5; b = 8'd3; op = 3'd0; av = 1'b1; bv = 1'b1;
    cycle();
    av = 1'b0; bv = 1'b0;
    repeat (P + 2) cycle();

    // Back-to-back sweep of all operations.
    for (int i = 0; i < 8; i++) begin
      a = 8'hF0; b = 8'h20; op = 3'(i); av = 1'b1; bv = 1'b1;
      cycle();
    end
    av = 1'b0; bv = 1'b0;
    repeat (P + 2) cycle();

    // One operand alone is never consumed.
    a = 8'd77; b = 8'd11; op = 3'd7; av = 1'b1; bv = 1'b0;
    repeat (5) cycle();
    bv = 1'b1;
    cycle();
    av = 1'b0; bv = 1'b0;
    repeat (P + 2) cycle();

    // Stall from empty: exactly P fires, then drain in order.
    fires_seen = 0;
    rr = 1'b0; av = 1'b1; bv = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a = DW'($urandom); b = DW'($urandom); op = 3'($urandom_range(0, 7));
      cycle();
    end
    check("stall_fires", 64'(fires_seen), 64'(P));
    av = 1'b0; bv = 1'b0; rr = 1'b1;
    repeat (P + 2) cycle();

    // Clear coincident with a result handshake.
    a = 8'd9; b = 8'd4; op = 3'd1; av = 1'b1; bv = 1'b1;
    cycle();
    av = 1'b0; bv = 1'b0;
    repeat (P - 1) cycle();
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    check("clear_vs_handshake", 64'(cnt), 64'(0));
    repeat (2) cycle();

    // Random traffic with random backpressure and occasional clears.
    for (int i = 0; i < 400; i++) begin
      a   = DW'($urandom);
      b   = DW'($urandom);
      op  = 3'($urandom_range(0, 7));
      av  = ($urandom_range(0, 3) != 0);
      bv  = ($urandom_range(0, 3) != 0);
      rr  = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 31) == 0);
      cycle();
    end
    av = 1'b0; bv = 1'b0; clr = 1'b0; rr = 1'b1;
    repeat (P + 2) cycle();

    // Asynchronous reset with results in flight.
    rr = 1'b0; av = 1'b1; bv = 1'b1; a = 8'd1; b = 8'd2; op = 3'd0;
    repeat (P) cycle();
    av = 1'b0; bv = 1'b0;
    cycle();
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_result_valid", 64'(res_vld), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_op_count", 64'(cnt), 64'(0));
    q.delete();
    exp_count = '0;
    @(negedge clk);
    rst_n = 1'b1;
    rr = 1'b1;
    repeat (P + 3) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
